// File: rtl/seq_bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, the double-dabble adjust constants and a power-of-ten helper.
package bcd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] ADJ_THRESH  = 4'd5;
    localparam logic [3:0] ADJ_ADD     = 4'd3;

    // Elaboration-time 10**n, used for the overflow limit.
    function automatic int unsigned pow10(input int n);
        int unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_bin2bcd_if.sv
// Upstream start/busy/valid handshake plus the held BCD result for seq_bin2bcd.
// master drives the request side, slave is the converter.
interface seq_bin2bcd_if #(
    parameter int BIN_W  = 13,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  valid;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (
        output start, bin,
        input  busy, valid, bcd, overflow
    );

    modport slave (
        input  start, bin,
        output busy, valid, bcd, overflow
    );
endinterface

// File: rtl/seq_bin2bcd_digit_adj.sv
// Combinational double-dabble cell: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= ADJ_THRESH) begin
            digit_o = digit_i + ADJ_ADD;
        end
    end

endmodule

// File: rtl/seq_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock, result held between conversions.
// Optional macro SEQ_BIN2BCD_AUTO_CONVERT_EN: ignore start and relaunch a conversion on every IDLE cycle.
module seq_bin2bcd
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 13,
    parameter int DIGITS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_bin2bcd_if.slave  bus
);

    localparam int          SCR_W   = BCD_DIGIT_W * DIGITS;
    localparam int          CNT_W   = $clog2(BIN_W + 1);
    localparam int unsigned LIMIT   = pow10(DIGITS);
    localparam logic [SCR_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    state_e             state_q;
    logic [BIN_W-1:0]   shreg_q;
    logic [SCR_W-1:0]   scratch_q;
    logic [CNT_W-1:0]   count_q;
    logic               ovf_pend_q;
    logic               busy_q;
    logic               valid_q;
    logic [SCR_W-1:0]   bcd_q;
    logic               overflow_q;

    logic [SCR_W-1:0]   scr_adj;
    logic [SCR_W-1:0]   scratch_d;
    logic [BIN_W-1:0]   shreg_d;
    logic [CNT_W-1:0]   count_d;
    logic               ovf_in;
    logic               start_eff;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit_i (scratch_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .digit_o (scr_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // Adjusted scratch and the binary shift register move left together as one wide register.
    assign scratch_d = {scr_adj[SCR_W-2:0], shreg_q[BIN_W-1]};
    assign shreg_d   = {shreg_q[BIN_W-2:0], 1'b0};
    assign count_d   = count_q - CNT_W'(1);
    assign ovf_in    = 32'(bus.bin) >= LIMIT;

`ifdef SEQ_BIN2BCD_AUTO_CONVERT_EN
    assign start_eff = 1'b1;
`else
    assign start_eff = bus.start;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            scratch_q  <= '0;
            count_q    <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_eff) begin
                        shreg_q    <= bus.bin;
                        scratch_q  <= '0;
                        count_q    <= CNT_W'(BIN_W);
                        ovf_pend_q <= ovf_in;
                        busy_q     <= 1'b1;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg_q   <= shreg_d;
                    scratch_q <= scratch_d;
                    count_q   <= count_d;
                    // Last shift: publish the whole result on one edge so the display never sees a partial value.
                    if (count_q == CNT_W'(1)) begin
                        bcd_q      <= ovf_pend_q ? ALL_NINES : scratch_d;
                        overflow_q <= ovf_pend_q;
                        valid_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.valid    = valid_q;
    assign bus.bcd      = bcd_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Directed, table-driven bench for seq_bin2bcd: default 13-bit/4-digit instance plus a
// 10-bit/3-digit instance for the overflow saturation cases.
module tb_seq_bin2bcd;

    logic clk;
    logic rst_n;

    int n_cmp = 0;
    int n_err = 0;

    seq_bin2bcd_if #(.BIN_W(13), .DIGITS(4)) bus0 ();
    seq_bin2bcd_if #(.BIN_W(10), .DIGITS(3)) bus1 ();

    seq_bin2bcd #(.BIN_W(13), .DIGITS(4)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    seq_bin2bcd #(.BIN_W(10), .DIGITS(3)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] bin;
        logic [15:0] exp_bcd;
    } vec_t;

    typedef struct {
        logic [9:0]  bin;
        logic [11:0] exp_bcd;
        logic        exp_ovf;
    } vec_s_t;

    vec_t   vecs[8];
    vec_s_t vecs_s[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic conv_big(input logic [12:0] b, input logic [15:0] exp);
        int lat, nval;
        logic busy_ok;
        logic [15:0] got;
        bus0.start = 1'b1;
        bus0.bin   = b;
        tick();
        bus0.start = 1'b0;
        busy_ok = bus0.busy;
        lat = -1; nval = 0; got = '0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bus0.valid === 1'b1) begin
                nval++;
                if (lat < 0) begin
                    lat = k;
                    got = bus0.bcd;
                end
            end
            if (k < 13 && bus0.busy !== 1'b1) busy_ok = 1'b0;
        end
        $display("conv13 bin=%0d bcd=%h latency=%0d valids=%0d", b, got, lat, nval);
        check("latency", lat, 13);
        check("valid_count", nval, 1);
        check("bcd", 32'(got), 32'(exp));
        check("overflow", 32'(bus0.overflow), 0);
        check("busy_window", 32'(busy_ok), 1);
        check("bcd_hold", 32'(bus0.bcd), 32'(exp));
    endtask

    task automatic conv_small(input logic [9:0] b, input logic [11:0] exp, input logic ovf);
        int lat;
        logic [11:0] got;
        logic got_ovf;
        bus1.start = 1'b1;
        bus1.bin   = b;
        tick();
        bus1.start = 1'b0;
        lat = -1; got = '0; got_ovf = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (bus1.valid === 1'b1 && lat < 0) begin
                lat = k;
                got = bus1.bcd;
                got_ovf = bus1.overflow;
            end
        end
        $display("conv10 bin=%0d bcd=%h overflow=%0b latency=%0d", b, got, got_ovf, lat);
        check("small_latency", lat, 10);
        check("small_bcd", 32'(got), 32'(exp));
        check("small_overflow", 32'(got_ovf), 32'(ovf));
    endtask

    initial begin
        int lat, nval;

        vecs[0] = '{13'd255,  16'h0255};
        vecs[1] = '{13'd8191, 16'h8191};
        vecs[2] = '{13'd0,    16'h0000};
        vecs[3] = '{13'd1234, 16'h1234};
        vecs[4] = '{13'd5,    16'h0005};
        vecs[5] = '{13'd1000, 16'h1000};
        vecs[6] = '{13'd4095, 16'h4095};
        vecs[7] = '{13'd999,  16'h0999};

        vecs_s[0] = '{10'd1000, 12'h999, 1'b1};
        vecs_s[1] = '{10'd999,  12'h999, 1'b0};
        vecs_s[2] = '{10'd1023, 12'h999, 1'b1};
        vecs_s[3] = '{10'd500,  12'h500, 1'b0};

        // Reset held with start asserted: outputs must stay at reset values.
        rst_n = 1'b0;
        bus0.start = 1'b1; bus0.bin = 13'd123;
        bus1.start = 1'b0; bus1.bin = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("reset_outputs", {bus0.busy, bus0.valid, bus0.overflow, bus0.bcd}, 0);
        end
        $display("reset held 4 cycles with start=1");
        bus0.start = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_reset_idle", {bus0.busy, bus0.valid}, 0);

        for (int i = 0; i < 8; i++) begin
            conv_big(vecs[i].bin, vecs[i].exp_bcd);
        end

        // Start while busy is ignored; a start in the valid cycle is accepted.
        bus0.start = 1'b1; bus0.bin = 13'd42;
        tick();
        bus0.start = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        bus0.start = 1'b1; bus0.bin = 13'd999;
        tick();
        bus0.start = 1'b0;
        nval = 0;
        for (int k = 6; k <= 13; k++) begin
            tick();
            if (bus0.valid === 1'b1) nval++;
        end
        $display("busy-protect first result bcd=%h valid=%0b", bus0.bcd, bus0.valid);
        check("protect_valid", 32'(bus0.valid), 1);
        check("protect_bcd", 32'(bus0.bcd), 32'h0042);
        check("protect_valid_count", nval, 1);
        bus0.start = 1'b1; bus0.bin = 13'd999;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            bus0.start = 1'b0;
            if (bus0.valid === 1'b1 && lat < 0) lat = k;
        end
        $display("start in valid cycle: result bcd=%h after %0d cycles", bus0.bcd, lat);
        check("valid_cycle_start_latency", lat, 14);
        check("valid_cycle_start_bcd", 32'(bus0.bcd), 32'h0999);

        // Reset mid-conversion aborts without a valid pulse.
        bus0.start = 1'b1; bus0.bin = 13'd4095;
        tick();
        bus0.start = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        rst_n = 1'b0;
        tick();
        tick();
        check("midreset_outputs", {bus0.busy, bus0.valid, bus0.overflow, bus0.bcd}, 0);
        rst_n = 1'b1;
        nval = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (bus0.valid === 1'b1) nval++;
        end
        $display("mid-conversion reset: valids after release=%0d bcd=%h", nval, bus0.bcd);
        check("midreset_no_valid", nval, 0);
        check("midreset_bcd", 32'(bus0.bcd), 0);
        conv_big(13'd4095, 16'h4095);

        for (int i = 0; i < 4; i++) begin
            conv_small(vecs_s[i].bin, vecs_s[i].exp_bcd, vecs_s[i].exp_ovf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
